// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
// Holds the occupancy-state encoding, default field widths and the
// packed per-stage control structs that stages cast into in_ctrl.
package pipe_pkg;

  // Occupancy of a stage register: main slot M and optional skid slot S.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // M invalid
    ONE   = 2'd1,  // M valid, S invalid
    TWO   = 2'd2   // M and S valid
  } pipe_state_e;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;

  // ID/EX control bundle (8 bits).
  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] wb_sel;
    logic       reg_wen;
  } id_ex_ctrl_t;

  // EX/MEM control bundle (8 bits).
  typedef struct packed {
    logic [4:0] rd;
    logic       wb_sel;
    logic       reg_wen;
    logic       mem_rw;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones and never wraps.
// Synchronous active-high clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step up unless already pinned at the maximum.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with flush,
// synchronous clear and a saturating downstream-stall counter.
// Build option PIPE_SKID_EN: adds a skid slot S so in_ready comes from
// registered state only; without it capacity is one beat and in_ready is
// combinational (!out_valid | out_ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W             = PIPE_DATA_W,
  parameter int CTRL_W             = PIPE_CTRL_W,
  parameter int CNT_W              = 16,
  parameter bit ZERO_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e state_q, state_d;

  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
`ifdef PIPE_SKID_EN
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
`endif

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; clear returns the stage to EMPTY.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy from the two handshakes; flush empties the stage.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
`ifdef PIPE_SKID_EN
          if (in_fire && !out_fire) begin
            state_d = TWO;
          end else if (!in_fire && out_fire) begin
            state_d = EMPTY;
          end
`else
          if (!in_fire && out_fire) state_d = EMPTY;
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: if (out_fire) state_d = ONE;
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded from occupancy.
  always_comb begin
    out_valid = (state_q != EMPTY);
`ifdef PIPE_SKID_EN
    in_ready  = (state_q != TWO);
`else
    in_ready  = (state_q == EMPTY) | out_ready;
`endif
  end

  // Slot contents: load M (or S when M is stuck), promote S to M, or kill.
  always_comb begin
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
`ifdef PIPE_SKID_EN
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
`endif
    if (flush) begin
      m_ctrl_d = '0;
      if (ZERO_DATA_ON_FLUSH) m_data_d = '0;
`ifdef PIPE_SKID_EN
      s_ctrl_d = '0;
      if (ZERO_DATA_ON_FLUSH) s_data_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ONE: begin
`ifdef PIPE_SKID_EN
          if (in_fire && out_fire) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (in_fire) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end
`else
          // Without a skid slot, in_fire in ONE implies out_fire.
          if (in_fire) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (out_fire) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Slot registers; clear zeroes control and payload alike.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are reset here (unlike a RAM) because out_data=0 after clear is visible downstream.
    if (clear) begin
      m_ctrl_q <= '0;
      m_data_q <= '0;
`ifdef PIPE_SKID_EN
      s_ctrl_q <= '0;
      s_data_q <= '0;
`endif
    end else begin
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
`ifdef PIPE_SKID_EN
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
`endif
    end
  end

  assign out_ctrl = m_ctrl_q;
  assign out_data = m_data_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(clear),
    .inc(out_valid & ~out_ready),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg
// against a queue-based reference model (capacity 2 with PIPE_SKID_EN,
// else 1). A second instance with CNT_W=4 shares the stimulus so the
// stall counter's saturation is observed alongside the 16-bit one.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready_s, out_valid_s;
  logic [CW-1:0] out_ctrl_s;
  logic [DW-1:0] out_data_s;
  logic [3:0]    stall_cnt_s;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .ZERO_DATA_ON_FLUSH(1'b1)) dut (
    .clk(clk), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4), .ZERO_DATA_ON_FLUSH(1'b1)) dut_sat (
    .clk(clk), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  beat_t mq[$];       // beats held by the stage, oldest first
  int    stall_m = 0; // unsaturated stall-cycle count
  bit    zero_m  = 1; // outputs must read zero while empty (after clear/flush)

  function automatic bit model_in_ready();
`ifdef PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    bit m_ready, m_valid;
    beat_t b;
    @(posedge clk);
    m_ready = model_in_ready();
    m_valid = (mq.size() != 0);
    if (clear) begin
      mq.delete();
      stall_m = 0;
      zero_m  = 1;
    end else begin
      if (m_valid && !out_ready) stall_m++;
      if (flush) begin
        mq.delete();
        zero_m = 1;
      end else begin
        if (m_valid && out_ready) begin
          b = mq.pop_front();
          zero_m = 0;
        end
        if (in_valid && m_ready) begin
          mq.push_back({in_ctrl, in_data});
          zero_m = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step();
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 32'hDEAD; in_ctrl = 8'h5A;
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests_run++; if (out_ctrl !== '0) begin tests_failed++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    tests_run++; if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    do_clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_valid = (i <= 8);
      in_data  = DW'(i);
      in_ctrl  = CW'(i + 16);
      @(negedge clk);
      if (i >= 2) begin
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b want 1", i - 1, out_valid); end
        tests_run++; if (out_data !== DW'(i - 1)) begin tests_failed++; $display("FAIL stream_data[%0d]: got %h want %h", i - 1, out_data, DW'(i - 1)); end
        tests_run++; if (out_ctrl !== CW'(i - 1 + 16)) begin tests_failed++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i - 1, out_ctrl, CW'(i - 1 + 16)); end
      end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      tests_run++; if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL stream_stall[%0d]: got %0d want 0", i, stall_cnt); end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] beats[3];
    logic [DW-1:0] got[$];
    int idx = 0;
    beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC;
    do_clear();
    in_ctrl = 8'h00;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? beats[idx] : '0;
      @(negedge clk);
      tests_run++; if (in_ready !== model_in_ready()) begin tests_failed++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", cyc, in_ready, model_in_ready()); end
      if (cyc >= 2 && cyc <= 4) begin
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_blocked[c%0d]: got %b want 0", cyc, in_ready); end
      end
      if (cyc >= 1 && cyc <= 4) begin
        tests_run++; if (out_data !== 32'hA) begin tests_failed++; $display("FAIL bp_hold[c%0d]: got %h want a", cyc, out_data); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && model_in_ready()) idx++;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (got.size() != 3) begin tests_failed++; $display("FAIL bp_count: got %0d beats want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      tests_run++; if (got[k] !== beats[k]) begin tests_failed++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], beats[k]); end
    end
    tests_run++; if (stall_cnt !== 16'd4) begin tests_failed++; $display("FAIL bp_stall_cnt: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_flush_two();
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h01;
    step();
    in_data = 32'h22; in_ctrl = 8'h02;
    step();
    flush = 1'b1; in_data = 32'h33; in_ctrl = 8'h03; out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_data !== 32'h11) begin tests_failed++; $display("FAIL flush_pre_head: got %h want 11", out_data); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tests_run++; if (out_ctrl !== '0) begin tests_failed++; $display("FAIL flush_ctrl: got %h want 0", out_ctrl); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL flush_data: got %h want 0", out_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0 || out_data === 32'h33) begin tests_failed++; $display("FAIL flush_ghost[%0d]: valid %b data %h want invalid, never 33", k, out_valid, out_data); end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] held;
    held = $urandom;
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1; in_data = held; in_ctrl = 8'h77;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b1 || out_data !== held) begin tests_failed++; $display("FAIL sat_stable[%0d]: valid %b data %h want 1 %h", k, out_valid, out_data, held); end
      step();
    end
    @(negedge clk);
    tests_run++; if (stall_cnt !== 16'd20) begin tests_failed++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); end
    tests_run++; if (stall_cnt_s !== 4'd15) begin tests_failed++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt_s); end
  endtask

  task automatic test_ready_path();
    logic exp_lo;
`ifdef PIPE_SKID_EN
    exp_lo = 1'b1;
`else
    exp_lo = 1'b0;
`endif
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5; in_ctrl = 8'h05;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; #1;
    tests_run++; if (in_ready !== exp_lo) begin tests_failed++; $display("FAIL ready_one_lo: got %b want %b", in_ready, exp_lo); end
    out_ready = 1'b1; #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_one_hi: got %b want 1", in_ready); end
    out_ready = 1'b0; #1;
    tests_run++; if (in_ready !== exp_lo) begin tests_failed++; $display("FAIL ready_one_lo2: got %b want %b", in_ready, exp_lo); end
    in_valid = 1'b1; in_data = 32'h6; in_ctrl = 8'h06;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; #1;
    tests_run++; if (in_ready !== ~exp_lo) begin tests_failed++; $display("FAIL ready_full_hi: got %b want %b", in_ready, ~exp_lo); end
    out_ready = 1'b0; #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_full_lo: got %b want 0", in_ready); end
    step();
  endtask

  task automatic test_random(input int n);
    do_clear();
    for (int k = 0; k < n; k++) begin
      clear     = ($urandom_range(63) == 0);
      flush     = ($urandom_range(19) == 0);
      in_valid  = $urandom_range(1);
      out_ready = (k % 100 < 50) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      @(negedge clk);
      tests_run++; if (in_ready !== model_in_ready()) begin tests_failed++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", k, in_ready, model_in_ready()); end
      tests_run++; if (out_valid !== (mq.size() != 0)) begin tests_failed++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", k, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        tests_run++; if (out_data !== mq[0].data || out_ctrl !== mq[0].ctrl) begin tests_failed++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", k, out_ctrl, out_data, mq[0].ctrl, mq[0].data); end
      end else if (zero_m) begin
        tests_run++; if (out_data !== '0 || out_ctrl !== '0) begin tests_failed++; $display("FAIL rnd_zero[%0d]: got %h/%h want 0/0", k, out_ctrl, out_data); end
      end
      tests_run++; if (stall_cnt !== 16'(stall_m)) begin tests_failed++; $display("FAIL rnd_stall16[%0d]: got %0d want %0d", k, stall_cnt, stall_m); end
      tests_run++; if (stall_cnt_s !== sat4(stall_m)) begin tests_failed++; $display("FAIL rnd_stall4[%0d]: got %0d want %0d", k, stall_cnt_s, sat4(stall_m)); end
      step();
    end
    clear = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_saturation();
    test_ready_path();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register. It is the generalised successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary control field and data field with a valid/ready handshake, flush, and an optional two-entry skid buffer, so back-pressure from a stalled downstream stage never combinationally reaches upstream. It also counts downstream stall cycles for performance analysis.

## Interface
Parameters:
- DATA_W, 64, payload width (ALU result, PC, rs2, ... packed by the instantiating stage)
- CTRL_W, 8, control width (rd, WBsel, RegWEn, memRW, ...)
- CNT_W, 16, stall counter width
- ZERO_DATA_ON_FLUSH, 1, 1: data registers cleared on flush; 0: data held, only valid/ctrl cleared

Ports:
- clk  in  1  clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries (branch mispredict / trap)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  held control
- out_data  out  DATA_W  held payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Two storage slots: main M (drives outputs) and skid S (only with PIPE_SKID_EN).
- States: EMPTY (M invalid), ONE (M valid, S invalid), TWO (M and S valid).
- EMPTY: in_fire -> ONE, M<=in.
- ONE: in_fire & out_fire -> ONE, M<=in. in_fire & !out_fire -> TWO, S<=in. !in_fire & out_fire -> EMPTY.
- TWO: in_ready=0. out_fire -> ONE, M<=S. Otherwise hold.
- in_ready = !S_valid, from a register; it has no combinational dependence on out_ready.
- Order is strictly FIFO. No beat is duplicated or dropped except by flush.
- flush: next state EMPTY. M and S valid and ctrl are cleared to 0. Data is cleared to 0 when ZERO_DATA_ON_FLUSH=1, otherwise held. A beat presented during the flush cycle is discarded even if in_fire. flush does not touch stall_cnt.
- clear: same as flush, plus data always cleared and stall_cnt<=0. clear has priority over flush and handshakes.
- stall_cnt: +1 each cycle out_valid & !out_ready. Saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. in_ready=1 in the cycle after clear.
- Latency in_fire -> out_valid: 1 cycle.
- Throughput: 1 beat/cycle when out_ready is held high.
- in_ready falls the cycle after entering TWO and rises the cycle after leaving it.
- out_* is stable while out_valid & !out_ready, except across flush/clear.
- Simultaneous in_fire and out_fire in ONE: the outgoing beat leaves and the new beat lands in M; no bubble.

## Configuration
- PIPE_SKID_EN defined: behaviour as above, with registered in_ready, up to 2 entries and states EMPTY/ONE/TWO.
- Not defined: S is absent and only EMPTY/ONE exist. in_ready = !out_valid | out_ready, combinational. In-flight capacity is 1. flush, clear, stall_cnt and latency are unchanged.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - default width constants PIPE_DATA_W and PIPE_CTRL_W;
  - packed per-stage ctrl structs, which stages cast into in_ctrl.
- Sub-module sat_counter (param W; inc and clr inputs) implements stall_cnt. It is reused by other perf counters.

## Test plan
- Reset: assert clear with in_valid=1 and in_data=0xDEAD -> next cycle out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, feed 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each one cycle after input; stall_cnt stays 0.
- Back-pressure (skid): drive 0xA, 0xB, 0xC with out_ready=0 from cycle 1:
  - 0xA and 0xB are held;
  - in_ready=0 from the cycle after 0xB is accepted, and 0xC waits;
  - raise out_ready -> 0xA, 0xB, 0xC emerge in order;
  - stall_cnt equals the number of stalled cycles.
- Flush in TWO: with M=0x11 and S=0x22, assert flush while presenting 0x33 -> next cycle out_valid=0, out_ctrl=0, out_data=0 (ZERO_DATA_ON_FLUSH=1), and 0x33 never appears.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- No-skid build (PIPE_SKID_EN undefined): when out_valid=1 and out_ready=0, in_ready=0 in the same cycle. Toggling out_ready toggles in_ready combinationally.
